fib_seq_engine: RTL

Multi-channel, parametrised successor to the single Fibonacci generator: CHANNELS independent Fibonacci sequence channels, each WIDTH bits, advanced by one shared programmable tick divider in the single wb_clk_i domain. Replaces the clock-muxed generator with clock enables. Sits behind the Wishbone slave port of the user project and drives the IO pads through value_o. Adds per-channel seeding, halt-or-wrap overflow handling, sticky overflow status and an interrupt.

---
 rtl/fib_seq_engine_if.sv | 23 ++
 rtl/fib_seq_engine.sv | 131 +++++++++++++
 2 files changed

// File: rtl/fib_seq_engine_if.sv
// Wishbone slave bus bundle for fib_seq_engine (single wb_clk_i domain).
// Handshake: a request is valid while wbs_stb_i & wbs_cyc_i are high; the slave completes it
// with a single-cycle wbs_ack_o (ready), and the master holds the request until it sees that ack.
interface fib_seq_engine_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/fib_seq_engine.sv
// Multi-channel Fibonacci generator stepped by a shared programmable tick divider.
// Optional macro FIB_IRQ_EN adds the IRQ_EN register and a registered interrupt output.
module fib_seq_engine #(
  parameter int          WIDTH        = 30,
  parameter int          CHANNELS     = 2,
  parameter int          DIV_WIDTH    = 36,
  parameter logic [23:0] BASE_ADDRESS = 24'h300000
) (
  input  logic                      wb_clk_i,
  input  logic                      reset,
  fib_seq_engine_if.slave           wb,
  output logic [CHANNELS*WIDTH-1:0] value_o,
  output logic                      tick_o,
  output logic                      irq
);
  localparam logic [31:0] ID_VALUE = 32'h4669626F;
  localparam logic [6:0]  DIV_W7   = 7'(DIV_WIDTH);

  logic [CHANNELS-1:0]  enable, mode, status, irq_en;
  logic [5:0]           div_tap;
  logic [DIV_WIDTH-1:0] counter;
  logic [WIDTH-1:0]     a_q    [CHANNELS];
  logic [WIDTH-1:0]     b_q    [CHANNELS];
  logic [WIDTH-1:0]     seed_q [CHANNELS];

  logic                 req, wr, tick_cond;
  logic [5:0]           word;
  logic [31:0]          rd_data;
  logic [CHANNELS-1:0]  seed_wr, ovf_set, status_clr;
  logic [WIDTH:0]       sum [CHANNELS];
  logic [6:0]           tap_eff;
  logic [DIV_WIDTH-1:0] tap_mask;
  logic                 unused_bits;

  assign unused_bits = ^{wb.wbs_dat_i, wb.wbs_adr_i[1:0]};

  always_comb begin
    // Gating on the current ack keeps a held strobe from being accepted twice in a row.
    req        = wb.wbs_stb_i & wb.wbs_cyc_i & (wb.wbs_adr_i[31:8] == BASE_ADDRESS) & ~wb.wbs_ack_o;
    wr         = req & wb.wbs_we_i & (wb.wbs_sel_i == 4'hF);
    word       = wb.wbs_adr_i[7:2];
    status_clr = (wr && word == 6'd3) ? wb.wbs_dat_i[CHANNELS-1:0] : '0;
    rd_data    = '0;
    value_o    = '0;
    case (word)
      6'd0: rd_data = ID_VALUE;
      6'd1: begin
        rd_data[CHANNELS-1:0]  = enable;
        rd_data[8 +: CHANNELS] = mode;
      end
      6'd2: rd_data[5:0] = div_tap;
      6'd3: rd_data[CHANNELS-1:0] = status;
      6'd4: rd_data[CHANNELS-1:0] = irq_en;
      default: ;
    endcase
    for (int c = 0; c < CHANNELS; c++) begin
      sum[c]     = {1'b0, a_q[c]} + {1'b0, b_q[c]};
      seed_wr[c] = wr && (word == 6'(9 + 2 * c));
      // A restart in the same cycle discards the step, including its overflow.
      ovf_set[c] = tick_o & enable[c] & sum[c][WIDTH] & ~seed_wr[c];
      if (word == 6'(8 + 2 * c)) rd_data = 32'(a_q[c]);
      value_o[c*WIDTH +: WIDTH] = a_q[c];
    end
    tap_eff   = ({1'b0, div_tap} >= DIV_W7) ? DIV_W7 : {1'b0, div_tap};
    tap_mask  = ~({DIV_WIDTH{1'b1}} << tap_eff);
    tick_cond = ((counter & tap_mask) == tap_mask);
  end

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      enable       <= '0;
      mode         <= '0;
      status       <= '0;
      div_tap      <= '0;
      counter      <= '0;
      tick_o       <= 1'b0;
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        a_q[c]    <= '0;
        b_q[c]    <= WIDTH'(1);
        seed_q[c] <= WIDTH'(1);
      end
    end else begin
      wb.wbs_ack_o <= req;
      wb.wbs_dat_o <= (req & ~wb.wbs_we_i) ? rd_data : '0;
      tick_o       <= tick_cond;
      if (wr && word == 6'd1) begin
        enable <= wb.wbs_dat_i[CHANNELS-1:0];
        mode   <= wb.wbs_dat_i[8 +: CHANNELS];
      end
      if (wr && word == 6'd2) begin
        div_tap <= wb.wbs_dat_i[5:0];
        counter <= '0;
      end else begin
        counter <= counter + DIV_WIDTH'(1);
      end
      status <= (status & ~status_clr) | ovf_set;
      for (int c = 0; c < CHANNELS; c++) begin
        if (seed_wr[c]) begin
          seed_q[c] <= wb.wbs_dat_i[WIDTH-1:0];
          a_q[c]    <= '0;
          b_q[c]    <= wb.wbs_dat_i[WIDTH-1:0];
        end else if (tick_o && enable[c]) begin
          if (!sum[c][WIDTH]) begin
            a_q[c] <= b_q[c];
            b_q[c] <= sum[c][WIDTH-1:0];
          end else if (mode[c]) begin
            a_q[c] <= '0;
            b_q[c] <= seed_q[c];
          end
        end
      end
    end
  end

`ifdef FIB_IRQ_EN
  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      irq_en <= '0;
      irq    <= 1'b0;
    end else begin
      if (wr && word == 6'd4) irq_en <= wb.wbs_dat_i[CHANNELS-1:0];
      irq <= |(status & irq_en);
    end
  end
`else
  assign irq_en = '0;
  assign irq    = 1'b0;
`endif
endmodule
